// File: rtl/clk_meas_pkg.sv
// Shared definitions for the clock period meter.
//   meas_state_t    : measurement FSM states
//   DEF_CNT_W       : default width of the cycle counter and result fields
//   DEF_SYNC_STAGES : default synchronizer depth on the measured input
//   DEF_TIMEOUT     : default count at which a measurement is abandoned
package clk_meas_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_MEASURE = 2'd2
    } meas_state_t;

    localparam int          DEF_CNT_W       = 33;
    localparam int          DEF_SYNC_STAGES = 2;
    localparam longint unsigned DEF_TIMEOUT = 64'd100_000_000;

endpackage

// File: rtl/clk_period_meter_sync_edge_detect.sv
// Synchronizer chain plus edge-detect flop for an asynchronous input.
// Reusable for buttons, strobes and other slow asynchronous signals.
//   clk_in  : sampling clock
//   rst_n   : asynchronous active-low reset
//   i_async : asynchronous input
//   o_level : synchronized level
//   o_rise  : one-cycle pulse on a synchronized 0->1 transition
//   o_fall  : one-cycle pulse on a synchronized 1->0 transition
module sync_edge_detect #(
    parameter int STAGES = 2
) (
    input  logic clk_in,
    input  logic rst_n,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_async};
            r_prev <= r_sync[STAGES-1];
        end
    end

    assign o_level = r_sync[STAGES-1];
    assign o_rise  = r_sync[STAGES-1] & ~r_prev;
    assign o_fall  = ~r_sync[STAGES-1] & r_prev;

endmodule

// File: rtl/clk_period_meter.sv
// Measures period and high time of a slow asynchronous clock-like input in
// clk_in cycles and hands results downstream over valid/ready.
//   clk_in, rst_n : system clock, asynchronous active-low reset
//   sig_in        : asynchronous signal under measurement
//   meas_en       : measurement enable (low forces IDLE)
//   period        : clk_in cycles between consecutive rising edges
//   high_time     : clk_in cycles from rising edge to following falling edge
//   meas_valid    : result held on period/high_time
//   meas_ready    : consumer accepts the result
//   timeout       : one-cycle pulse when a measurement is abandoned
//   overrun       : one-cycle pulse when an unaccepted result is overwritten
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | disabled, counter cleared
// ST_ARM     | waiting for the first rising edge to start counting
// ST_MEASURE | counting; each rising edge closes one period, opens the next
module clk_period_meter
    import clk_meas_pkg::*;
#(
    parameter int              CNT_W       = DEF_CNT_W,
    parameter int              SYNC_STAGES = DEF_SYNC_STAGES,
    parameter longint unsigned TIMEOUT     = DEF_TIMEOUT
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             sig_in,
    input  logic             meas_en,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    input  logic             meas_ready,
    output logic             timeout,
    output logic             overrun
);

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    meas_state_t      r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [CNT_W-1:0] r_hi_tmp, w_hi_tmp_nxt;
    logic             r_hi_seen, w_hi_seen_nxt;
    logic             w_capture, w_timeout;
    logic             w_rise, w_fall;
    // Only the edges matter here; the level output exists for other users.
    logic             w_unused_level;

    logic [CNT_W-1:0] r_period, r_high_time;
    logic             r_meas_valid, r_timeout, r_overrun;

    sync_edge_detect #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_in  (clk_in),
        .rst_n   (rst_n),
        .i_async (sig_in),
        .o_level (w_unused_level),
        .o_rise  (w_rise),
        .o_fall  (w_fall)
    );

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_hi_tmp  <= '0;
            r_hi_seen <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_hi_tmp  <= w_hi_tmp_nxt;
            r_hi_seen <= w_hi_seen_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_hi_tmp_nxt  = r_hi_tmp;
        w_hi_seen_nxt = r_hi_seen;
        w_capture     = 1'b0;
        w_timeout     = 1'b0;
        if (!meas_en) begin
            // Disable beats any edge arriving in the same cycle.
            w_state_nxt   = ST_IDLE;
            w_cnt_nxt     = '0;
            w_hi_seen_nxt = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_ARM;
                end
                ST_ARM: begin
                    if (w_rise) begin
                        w_cnt_nxt     = CNT_W'(1);
                        w_hi_seen_nxt = 1'b0;
                        w_state_nxt   = ST_MEASURE;
                    end
                end
                ST_MEASURE: begin
                    if (w_rise) begin
                        // Close this period and open the next one in the same cycle.
                        w_capture     = 1'b1;
                        w_cnt_nxt     = CNT_W'(1);
                        w_hi_seen_nxt = 1'b0;
                    end else if (r_cnt == TIMEOUT_C) begin
                        w_timeout     = 1'b1;
                        w_cnt_nxt     = '0;
                        w_hi_seen_nxt = 1'b0;
                        w_state_nxt   = ST_ARM;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                        if (w_fall && !r_hi_seen) begin
                            w_hi_tmp_nxt  = r_cnt;
                            w_hi_seen_nxt = 1'b1;
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_period     <= '0;
            r_high_time  <= '0;
            r_meas_valid <= 1'b0;
            r_timeout    <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_timeout <= w_timeout;
            // A capture coinciding with an accept is a clean hand-over, not an overrun.
            r_overrun <= w_capture && r_meas_valid && !meas_ready;
            if (w_capture) begin
                r_period     <= r_cnt;
                r_high_time  <= r_hi_seen ? r_hi_tmp : '0;
                r_meas_valid <= 1'b1;
            end else if (r_meas_valid && meas_ready) begin
                r_meas_valid <= 1'b0;
            end
        end
    end

    assign period     = r_period;
    assign high_time  = r_high_time;
    assign meas_valid = r_meas_valid;
    assign timeout    = r_timeout;
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_clk_period_meter.sv
module tb_clk_period_meter;

    localparam int              CNT_W = 33;
    localparam int              S     = 2;
    localparam longint unsigned TO    = 50;

    logic             clk_in = 1'b0;
    logic             rst_n;
    logic             sig_in;
    logic             meas_en;
    logic             meas_ready;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             meas_valid;
    logic             timeout;
    logic             overrun;

    always #5 clk_in = ~clk_in;

    clk_period_meter #(
        .CNT_W       (CNT_W),
        .SYNC_STAGES (S),
        .TIMEOUT     (TO)
    ) dut (
        .clk_in     (clk_in),
        .rst_n      (rst_n),
        .sig_in     (sig_in),
        .meas_en    (meas_en),
        .period     (period),
        .high_time  (high_time),
        .meas_valid (meas_valid),
        .meas_ready (meas_ready),
        .timeout    (timeout),
        .overrun    (overrun)
    );

    int checks   = 0;
    int failures = 0;

    // stimulus generator: divider with programmable high/low phase, or a held level
    bit gen_on;
    bit gen_level;
    int gen_hi, gen_lo, gen_cnt;

    // behavioural model: timestamps of edges as seen after the synchronizer delay
    longint           m_n = 0;
    longint           m_trise, m_tfall, m_p, m_h;
    logic [S:0]       m_hist;
    int               m_mode;   // 0 off, 1 waiting for first rise, 2 measuring
    bit               m_seen, m_rise, m_fall, m_xfer, m_cap;
    logic [CNT_W-1:0] e_period, e_high;
    bit               e_valid, e_timeout, e_overrun;

    // observation statistics
    int               tb_cyc = 0;
    int               xfer_cnt = 0, ovr_cnt = 0, to_cnt = 0, valid_cnt = 0;
    int               last_xfer_t = 0, prev_xfer_t = 0;
    logic [CNT_W-1:0] last_period = '0, last_high = '0;
    bit               neg_valid;

    task automatic model_reset();
        m_hist    = '0;
        m_mode    = 0;
        m_seen    = 1'b0;
        m_trise   = 0;
        m_tfall   = 0;
        e_period  = '0;
        e_high    = '0;
        e_valid   = 1'b0;
        e_timeout = 1'b0;
        e_overrun = 1'b0;
    endtask

    task automatic model_update();
        m_n++;
        if (!rst_n) begin
            model_reset();
        end else begin
            m_rise = m_hist[S-1] && !m_hist[S];
            m_fall = !m_hist[S-1] && m_hist[S];
            m_hist = {m_hist[S-1:0], sig_in};
            m_xfer = e_valid && meas_ready;
            m_cap  = 1'b0;
            e_timeout = 1'b0;
            if (!meas_en) begin
                m_mode = 0;
                m_seen = 1'b0;
            end else if (m_mode == 0) begin
                m_mode = 1;
            end else if (m_mode == 1) begin
                if (m_rise) begin
                    m_mode  = 2;
                    m_trise = m_n;
                    m_seen  = 1'b0;
                end
            end else begin
                if (m_rise) begin
                    m_cap   = 1'b1;
                    m_p     = m_n - m_trise;
                    m_h     = m_seen ? (m_tfall - m_trise) : 0;
                    m_trise = m_n;
                    m_seen  = 1'b0;
                end else if (m_n - m_trise == longint'(TO)) begin
                    e_timeout = 1'b1;
                    m_mode    = 1;
                    m_seen    = 1'b0;
                end else if (m_fall && !m_seen) begin
                    m_seen  = 1'b1;
                    m_tfall = m_n;
                end
            end
            e_overrun = m_cap && e_valid && !meas_ready;
            if (m_cap) begin
                e_period = CNT_W'(m_p);
                e_high   = CNT_W'(m_h);
                e_valid  = 1'b1;
            end else if (m_xfer) begin
                e_valid = 1'b0;
            end
        end
    endtask

    task automatic gen_tick();
        if (gen_on) begin
            gen_cnt++;
            if (sig_in && gen_cnt >= gen_hi) begin
                sig_in  = 1'b0;
                gen_cnt = 0;
            end else if (!sig_in && gen_cnt >= gen_lo) begin
                sig_in  = 1'b1;
                gen_cnt = 0;
            end
        end else begin
            sig_in  = gen_level;
            gen_cnt = 0;
        end
    endtask

    task automatic cycle_compare();
        checks++;
        if (period !== e_period || high_time !== e_high || meas_valid !== e_valid ||
            timeout !== e_timeout || overrun !== e_overrun) begin
            failures++;
            $display("FAIL cycle t=%0t actual p=%0d h=%0d v=%0b to=%0b ov=%0b required p=%0d h=%0d v=%0b to=%0b ov=%0b",
                     $time, period, high_time, meas_valid, timeout, overrun,
                     e_period, e_high, e_valid, e_timeout, e_overrun);
        end
        if (meas_valid && meas_ready) begin
            xfer_cnt++;
            last_period = period;
            last_high   = high_time;
            prev_xfer_t = last_xfer_t;
            last_xfer_t = tb_cyc;
        end
        if (overrun)    ovr_cnt++;
        if (timeout)    to_cnt++;
        if (meas_valid) valid_cnt++;
        neg_valid = meas_valid;
        tb_cyc++;
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            gen_tick();
            @(negedge clk_in);
            cycle_compare();
            @(posedge clk_in);
            model_update();
            #1;
        end
    endtask

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    int  base_a, base_b;
    bit  found;

    initial begin
        rst_n      = 1'b0;
        meas_en    = 1'b0;
        meas_ready = 1'b0;
        sig_in     = 1'b0;
        gen_on     = 1'b0;
        gen_level  = 1'b0;
        gen_hi     = 5;
        gen_lo     = 5;
        gen_cnt    = 0;
        model_reset();
        step(3);
        chk("reset_period", period, 0);
        chk("reset_high", high_time, 0);
        chk("reset_valid", meas_valid, 0);
        rst_n = 1'b1;

        // divider toggling every 5 cycles
        meas_en    = 1'b1;
        meas_ready = 1'b1;
        gen_on     = 1'b1;
        step(80);
        chk("div_period", last_period, 10);
        chk("div_high", last_high, 5);
        chk("div_spacing", last_xfer_t - prev_xfer_t, 10);

        // 3 high, 9 low
        gen_hi = 3;
        gen_lo = 9;
        step(60);
        chk("duty_period", last_period, 12);
        chk("duty_high", last_high, 3);

        // backpressure, aligned to a capture edge
        gen_hi = 5;
        gen_lo = 5;
        step(40);
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            step(1);
            found = neg_valid;
        end
        chk("bp_align_found", found, 1);
        step(7);
        meas_ready = 1'b0;
        base_a = ovr_cnt;
        step(25);
        chk("bp_overruns", ovr_cnt - base_a, 2);
        chk("bp_held_valid", meas_valid, 1);
        chk("bp_held_period", period, 10);
        meas_ready = 1'b1;
        base_b = xfer_cnt;
        step(2);
        chk("bp_valid_drop", meas_valid, 0);
        chk("bp_one_xfer", xfer_cnt - base_b, 1);

        // timeout: one rise then held high
        gen_on    = 1'b0;
        gen_level = 1'b0;
        meas_en   = 1'b0;
        step(3);
        meas_en = 1'b1;
        step(5);
        base_a = to_cnt;
        base_b = xfer_cnt;
        gen_level = 1'b1;
        step(80);
        chk("to_pulses", to_cnt - base_a, 1);
        chk("to_no_xfer", xfer_cnt - base_b, 0);
        chk("to_no_valid", meas_valid, 0);
        gen_level = 1'b0;
        step(10);
        gen_level = 1'b1;
        step(10);
        gen_level = 1'b0;
        step(10);
        gen_level = 1'b1;
        step(6);
        chk("to_after_period", last_period, 20);
        chk("to_after_high", last_high, 10);

        // meas_en dropped in the cycle the rise reaches the FSM
        gen_level = 1'b0;
        step(6);
        gen_level = 1'b1;
        step(2);
        meas_en = 1'b0;
        base_b = xfer_cnt;
        step(5);
        chk("en_no_capture", xfer_cnt - base_b, 0);
        chk("en_no_valid", meas_valid, 0);

        // reset mid-measurement with a pending result
        meas_en = 1'b1;
        gen_cnt = 0;
        gen_on  = 1'b1;
        step(40);
        meas_ready = 1'b0;
        step(25);
        chk("rst_pre_valid", meas_valid, 1);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_now_period", period, 0);
        chk("rst_now_high", high_time, 0);
        chk("rst_now_valid", meas_valid, 0);
        step(3);
        rst_n      = 1'b1;
        meas_ready = 1'b1;
        base_a = valid_cnt;
        step(10);
        chk("rst_no_early_valid", valid_cnt - base_a, 0);
        base_b = xfer_cnt;
        step(40);
        chk("rst_remeasure_period", last_period, 10);
        chk("rst_remeasure_seen", (xfer_cnt - base_b) > 0 ? 1 : 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/clk_period_meter.md
# clk_period_meter

Measures the period and high time of a slow, asynchronous clock-like input (e.g. a divided clock or an external strobe) in units of `clk_in` cycles. It is the receiving counterpart of the clock divider: the divider turns a count into a clock, and this block turns a clock back into a count. Results go to downstream logic (display, comparator, self-check) over a valid/ready handshake.

## Interface
Parameters:
- `CNT_W`, 33: width of the cycle counter and of the result fields.
- `SYNC_STAGES`, 2: number of synchronizer flops on `sig_in`; legal values are 2 or more.
- `TIMEOUT`, 100_000_000: counter value at which a measurement is abandoned; must satisfy 2 ≤ TIMEOUT < 2^CNT_W.

Ports:
- `clk_in`, in, 1: system clock.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `sig_in`, in, 1: asynchronous signal under measurement.
- `meas_en`, in, 1: enables measurement; low forces IDLE.
- `period`, out, CNT_W: clk_in cycles between consecutive rising edges.
- `high_time`, out, CNT_W: clk_in cycles from a rising edge to the following falling edge.
- `meas_valid`, out, 1: `period` and `high_time` hold a result.
- `meas_ready`, in, 1: consumer accepts the result.
- `timeout`, out, 1: one-cycle pulse when a measurement is abandoned.
- `overrun`, out, 1: one-cycle pulse when an unaccepted result is overwritten.

## Operation
- `sig_in` passes through the SYNC_STAGES synchronizer, then one edge-detect flop. The block produces `rise` and `fall` pulses, each one cycle long.
- The FSM has three states: IDLE, ARM and MEASURE.
  - IDLE: `cnt` = 0. Goes to ARM when `meas_en` = 1.
  - ARM: waits for `rise`. On `rise`, sets `cnt` to 1 and goes to MEASURE.
  - MEASURE: `cnt` increments by 1 each cycle.
- Capture in MEASURE:
  - On `fall`, if `hi_seen` = 0: latch `hi_tmp` = `cnt` and set `hi_seen`.
  - On `rise`: `period` = `cnt`, `high_time` = `hi_tmp`, `meas_valid` = 1. Then `cnt` = 1 and `hi_seen` = 0, and the FSM stays in MEASURE. Measurement is back-to-back with no lost period.
  - If a `rise` arrives with `hi_seen` = 0, `high_time` is reported as 0.
- Timeout: in MEASURE with `cnt` == TIMEOUT and no `rise`, pulse `timeout`, set `cnt` = 0 and return to ARM. `period` and `meas_valid` are unchanged.
- Handshake:
  - A result is transferred on a cycle with `meas_valid` && `meas_ready`. `meas_valid` drops the next cycle unless a new capture occurs in that same cycle.
  - Outputs stay stable while `meas_valid` && !`meas_ready`.
  - A capture while `meas_valid` && !`meas_ready` overwrites the result and pulses `overrun`.
  - A capture in the same cycle as an accept is not an overrun. The new result is loaded and `meas_valid` stays 1.
- `meas_en` low in any state: next state is IDLE, `cnt` = 0 and `hi_seen` = 0. A `rise` in that same cycle is ignored. A pending result stays valid until accepted.
- `cnt` never exceeds TIMEOUT, so no wrap-around is possible.

## Timing
- Reset values (asynchronous, `rst_n` = 0): FSM in IDLE; synchronizer and edge flops 0; `cnt`, `hi_tmp`, `hi_seen`, `period`, `high_time` = 0; `meas_valid`, `timeout`, `overrun` = 0.
- Assertion of `rst_n` mid-measurement discards all state immediately. Deassertion of `rst_n` is synchronous to `clk_in`.
- Latency: a `sig_in` transition reaches `rise`/`fall` SYNC_STAGES+1 cycles later. `meas_valid` rises the cycle after the capturing `rise`.
- Minimum measurable high or low phase is 1 clk_in cycle after synchronization. Shorter glitches may be missed.
- With a 50% input of period P cycles: `period` = P and `high_time` = P/2, ±1 depending on synchronizer phase.

## Structure
- Shared package `clk_meas_pkg`:
  - FSM state enum (IDLE, ARM, MEASURE).
  - Default constants CNT_W = 33, SYNC_STAGES = 2, TIMEOUT = 100_000_000.
- Sub-module `sync_edge_detect`: parameterized synchronizer chain plus the edge flop. Outputs the synchronized level, `rise` and `fall`. It is reusable for buttons and other asynchronous inputs.
- Top level contains the FSM, counter, capture registers and output handshake.

## Test plan
- **Divider stimulus:** drive `sig_in` from a divider toggling every 5 cycles, with `meas_ready` = 1. Expect first `meas_valid` after two `rise` edges; `period` = 10, `high_time` = 5; steady-state valid every 10 cycles.
- **Duty cycle:** 3 cycles high, 9 low → `period` = 12, `high_time` = 3.
- **Backpressure:** period-10 input, `meas_ready` = 0 for 25 cycles. Expect `meas_valid` held and `overrun` pulsed twice. The last result stays stable after ready rises, then transfers in one cycle.
- **Timeout:** TIMEOUT = 50; one `rise`, then `sig_in` held high. Expect `timeout` to pulse once when `cnt` = 50, FSM in ARM, no `meas_valid`. The next two rises 20 cycles apart give `period` = 20.
- **Enable and reset:** drop `meas_en` in the same cycle as a `rise` → no capture, FSM in IDLE. Assert `rst_n` = 0 mid-MEASURE → all outputs 0 immediately; after release, a full new measurement is required before valid.
